// File: rtl/cpu_pkg.sv
// cpu_pkg: shared control-decode constants and trace record layout for the CPU.
// Holds the op-class codes, the seven 10-bit control signatures
// {ALUop, resmux, ALUSrc, branch, memwrite, a2src, regwrite, jump},
// the trace record field offsets (relative to PC_W) and the inverse decode.
package cpu_pkg;

    localparam logic [2:0] OP_R    = 3'b000;
    localparam logic [2:0] OP_L    = 3'b001;
    localparam logic [2:0] OP_S    = 3'b010;
    localparam logic [2:0] OP_I    = 3'b011;
    localparam logic [2:0] OP_B    = 3'b100;
    localparam logic [2:0] OP_J    = 3'b101;
    localparam logic [2:0] OP_F    = 3'b110;
    localparam logic [2:0] OP_NONE = 3'b111;

    localparam logic [9:0] SIG_R = 10'b10_00_000110;
    localparam logic [9:0] SIG_L = 10'b00_01_100010;
    localparam logic [9:0] SIG_S = 10'b00_01_101000;
    localparam logic [9:0] SIG_I = 10'b10_00_100010;
    localparam logic [9:0] SIG_B = 10'b01_10_010000;
    localparam logic [9:0] SIG_J = 10'b00_10_000011;
    localparam logic [9:0] SIG_F = 10'b11_00_000110;

    // Record is {lost, err, op[2:0], pc}; offsets count up from bit PC_W.
    localparam int REC_OP_OFS   = 0;
    localparam int REC_ERR_OFS  = 3;
    localparam int REC_LOST_OFS = 4;

    // Returns {err, op}. The all-zero bundle is a bubble, not an error.
    function automatic logic [3:0] encode_ctrl(input logic [9:0] sig);
        return sig == SIG_R ? {1'b0, OP_R} :
               sig == SIG_L ? {1'b0, OP_L} :
               sig == SIG_S ? {1'b0, OP_S} :
               sig == SIG_I ? {1'b0, OP_I} :
               sig == SIG_B ? {1'b0, OP_B} :
               sig == SIG_J ? {1'b0, OP_J} :
               sig == SIG_F ? {1'b0, OP_F} :
               sig == '0    ? {1'b0, OP_NONE} : {1'b1, OP_NONE};
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// trace_fifo: parameterized synchronous FIFO with occupancy output.
// Ports: clk, rst (sync, active-high), push/din write side, pop/dout read side
// (dout always shows the head), full, empty, level (0..DEPTH).
// The caller only pushes when not full (or when popping the same cycle) and
// only pops when not empty.
module trace_fifo #(
    parameter int W     = 37,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [W-1:0]           din,
    input  logic                   pop,
    output logic [W-1:0]           dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= din;
    end

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign dout  = mem[rd_ptr[AW-1:0]];
    assign empty = wr_ptr == rd_ptr;
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level = wr_ptr - rd_ptr;

endmodule

// File: rtl/ctrl_trace_encoder.sv
// ctrl_trace_encoder: retirement trace that inverts the control decode to an op class.
// Ports: clk, rst (sync, active-high); ret_valid/ret_pc/ret_* retiring bundle
// (no backpressure); out_valid/out_ready/out_rec {lost, err, op, pc} trace sink;
// drop_cnt saturating drop count with drop_clr; fifo_level occupancy.
// Records that do not fit are dropped and the next accepted record carries lost = 1.
module ctrl_trace_encoder
    import cpu_pkg::*;
#(
    parameter int PC_W  = 32,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ret_valid,
    input  logic [PC_W-1:0]        ret_pc,
    input  logic [1:0]             ret_ALUop,
    input  logic [1:0]             ret_resmux,
    input  logic                   ret_ALUSrc,
    input  logic                   ret_branch,
    input  logic                   ret_memwrite,
    input  logic                   ret_a2src,
    input  logic                   ret_regwrite,
    input  logic                   ret_jump,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [PC_W+4:0]        out_rec,
    output logic [7:0]             drop_cnt,
    input  logic                   drop_clr,
    output logic [$clog2(DEPTH):0] fifo_level
);

    logic           lost;
    logic [3:0]     enc;
    logic [PC_W+4:0] rec;
    logic           full;
    logic           empty;
    logic           pop;
    logic           accept;
    logic           drop;

    assign enc = encode_ctrl({ret_ALUop, ret_resmux, ret_ALUSrc, ret_branch,
                              ret_memwrite, ret_a2src, ret_regwrite, ret_jump});

    always_comb begin
        rec = '0;
        rec[PC_W-1:0] = ret_pc;
        rec[PC_W+REC_OP_OFS +: 3] = enc[2:0];
        rec[PC_W+REC_ERR_OFS] = enc[3];
        rec[PC_W+REC_LOST_OFS] = lost;
    end

    // A full FIFO still takes a record when the sink drains one the same cycle.
    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;
    assign accept    = ret_valid && (!full || pop);
    assign drop      = ret_valid && !accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            lost     <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (accept) lost <= 1'b0;
            else if (drop) lost <= 1'b1;
            if (drop_clr) drop_cnt <= {7'd0, drop};
            else if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
        end
    end

    trace_fifo #(.W(PC_W + 5), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .din   (rec),
        .pop   (pop),
        .dout  (out_rec),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

endmodule

// File: tb/tb_ctrl_trace_encoder.sv
// tb_ctrl_trace_encoder: scoreboard bench with a queue-based reference model.
module tb_ctrl_trace_encoder;

    localparam int PC_W  = 32;
    localparam int DEPTH = 8;
    localparam int RW    = PC_W + 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             ret_valid;
    logic [PC_W-1:0]  ret_pc;
    logic [9:0]       bundle;
    logic             out_valid;
    logic             out_ready;
    logic [RW-1:0]    out_rec;
    logic [7:0]       drop_cnt;
    logic             drop_clr;
    logic [3:0]       fifo_level;

    always #5 clk = ~clk;

    ctrl_trace_encoder #(.PC_W(PC_W), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .ret_valid    (ret_valid),
        .ret_pc       (ret_pc),
        .ret_ALUop    (bundle[9:8]),
        .ret_resmux   (bundle[7:6]),
        .ret_ALUSrc   (bundle[5]),
        .ret_branch   (bundle[4]),
        .ret_memwrite (bundle[3]),
        .ret_a2src    (bundle[2]),
        .ret_regwrite (bundle[1]),
        .ret_jump     (bundle[0]),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_rec      (out_rec),
        .drop_cnt     (drop_cnt),
        .drop_clr     (drop_clr),
        .fifo_level   (fifo_level)
    );

    // Legal signatures in op order R, L, S, I, B, J, F.
    logic [9:0] legal [7] = '{10'b1000000110, 10'b0001100010, 10'b0001101000,
                             10'b1000100010, 10'b0110010000, 10'b0010000011,
                             10'b1100000110};

    int n_tests = 0;
    int n_fail  = 0;
    bit mon_en  = 0;

    logic [RW-1:0] sb [$];
    bit            m_lost = 0;
    int            m_drop = 0;
    bit            m_pop;
    bit            m_dropped;

    function automatic logic [3:0] ref_class(input logic [9:0] b);
        for (int i = 0; i < 7; i++)
            if (b == legal[i]) return {1'b0, 3'(i)};
        return (b == 10'd0) ? 4'b0111 : 4'b1111;
    endfunction

    function automatic logic [9:0] rand_bundle();
        int k;
        k = int'($urandom_range(9));
        if (k < 6) return legal[3'($urandom_range(6))];
        if (k < 7) return 10'd0;
        return 10'($urandom);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input logic v, input logic [9:0] b, input logic [31:0] pc,
                        input logic rdy, input logic clr, input logic r);
        ret_valid = v;
        bundle    = b;
        ret_pc    = pc;
        out_ready = rdy;
        drop_clr  = clr;
        rst       = r;
        @(negedge clk);
    endtask

    // Reference model: an ideal bounded queue plus a sticky loss flag.
    initial forever begin
        @(posedge clk);
        if (rst) begin
            sb.delete();
            m_lost = 0;
            m_drop = 0;
        end else begin
            m_pop = out_ready && sb.size() > 0;
            if (m_pop) void'(sb.pop_front());
            m_dropped = 0;
            if (ret_valid) begin
                if (sb.size() < DEPTH) begin
                    sb.push_back({m_lost, ref_class(bundle), ret_pc});
                    m_lost = 0;
                end else begin
                    m_lost = 1;
                    m_dropped = 1;
                end
            end
            if (drop_clr) m_drop = m_dropped ? 1 : 0;
            else if (m_dropped && m_drop < 255) m_drop++;
        end
    end

    // Monitor: compares the DUT's presented head and status against the model.
    initial forever begin
        @(negedge clk);
        if (mon_en) begin
            chk("valid", 64'(out_valid), 64'(sb.size() != 0));
            chk("level", 64'(fifo_level), 64'(sb.size()));
            chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
            if (out_valid && sb.size() > 0) chk("rec", 64'(out_rec), 64'(sb[0]));
        end
    end

    initial begin
        bit found;
        int ph;
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        mon_en = 1;
        chk("reset_valid", 64'(out_valid), 64'(0));
        chk("reset_level", 64'(fifo_level), 64'(0));
        chk("reset_drop", 64'(drop_cnt), 64'(0));

        step(1, legal[0], 32'h100, 0, 0, 0);
        chk("first_valid", 64'(out_valid), 64'(1));
        chk("first_rec", 64'(out_rec), 64'({2'b00, 3'b000, 32'h100}));

        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 8; i++) step(1, (i < 7) ? legal[i] : 10'd0, 32'h300 + 32'(i), 1, 0, 0);
        step(1, 10'b1101111111, 32'h400, 1, 0, 0);
        chk("err_bundle", 64'(out_rec[RW-1:PC_W]), 64'(5'b01111));

        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < DEPTH + 3; i++) step(1, rand_bundle(), 32'h500 + 32'(i), 0, 0, 0);
        chk("overflow_level", 64'(fifo_level), 64'(8));
        chk("overflow_drop", 64'(drop_cnt), 64'(3));

        step(1, legal[0], 32'h200, 1, 0, 0);
        chk("wrap_level", 64'(fifo_level), 64'(8));
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (out_rec[PC_W-1:0] == 32'h200) found = 1;
            else begin
                step(1, rand_bundle(), 32'h600 + 32'(i), 1, 0, 0);
                chk("wrap_level", 64'(fifo_level), 64'(8));
            end
        end
        chk("found_200", 64'(found), 64'(1));
        chk("lost_200", 64'(out_rec[RW-1]), 64'(1));
        step(1, rand_bundle(), 32'h700, 1, 0, 0);
        chk("lost_next", 64'({out_rec[RW-1], out_rec[PC_W-1:0]}), 64'({1'b0, 32'h600}));

        for (int i = 0; i < 300; i++) step(1, rand_bundle(), 32'(i), 0, 0, 0);
        chk("drop_sat", 64'(drop_cnt), 64'(255));
        step(1, rand_bundle(), 32'h800, 0, 1, 0);
        chk("drop_clr_drop", 64'(drop_cnt), 64'(1));

        for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) step(1, rand_bundle(), 32'h900 + 32'(i), 0, 0, 0);
        chk("pre_rst_level", 64'(fifo_level), 64'(5));
        step(0, 0, 0, 0, 0, 1);
        chk("mid_rst_valid", 64'(out_valid), 64'(0));
        chk("mid_rst_level", 64'(fifo_level), 64'(0));
        step(1, legal[3], 32'hA00, 0, 0, 0);
        chk("post_rst_rec", 64'(out_rec), 64'({2'b00, 3'b011, 32'hA00}));

        for (int i = 0; i < 4000; i++) begin
            ph = (i / 150) % 3;
            step($urandom_range(3) != 0, rand_bundle(), $urandom,
                 (ph == 0) ? 1'b1 : (ph == 1) ? 1'($urandom_range(1)) : ($urandom_range(7) == 0),
                 $urandom_range(49) == 0, $urandom_range(799) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ctrl_trace_encoder.md
# ctrl_trace_encoder

- Retirement-trace block for the pipelined CPU; sits at the writeback stage.
- Each cycle a retire strobe is high, it takes the retiring instruction's control bundle and inverts the main control decode back to the 3-bit op class.
- It tags the class with the PC and a consistency/loss flag, then buffers the record in a small FIFO that drains to a debug/trace sink over valid/ready.
- The CPU is never stalled; overflow drops records and counts them.

## Interface
Parameters:
- PC_W, 32, width of traced PC
- DEPTH, 8, FIFO entries; power of two, ≥2

Ports:
- clk  in  1  core clock
- rst  in  1  reset, synchronous, active-high
- ret_valid  in  1  an instruction retires this cycle; no backpressure
- ret_pc  in  PC_W  PC of retiring instruction
- ret_ALUop  in  2  retiring ALUop
- ret_resmux  in  2  retiring result-mux select
- ret_ALUSrc, ret_branch, ret_memwrite, ret_a2src, ret_regwrite, ret_jump  in  1 each  retiring control bits
- out_valid  out  1  record available
- out_ready  in  1  sink accepts record
- out_rec  out  PC_W+5  {lost, err, op[2:0], pc}
- drop_cnt  out  8  saturating count of dropped records
- drop_clr  in  1  clears drop_cnt
- fifo_level  out  $clog2(DEPTH)+1  current occupancy

## Operation
Encoding (combinational, input side):
- Concatenated signature order: {ALUop, resmux, ALUSrc, branch, memwrite, a2src, regwrite, jump}.
- Exact signature match sets op and clears err:
  - R = 000: 10,00,0,0,0,1,1,0
  - L = 001: 00,01,1,0,0,0,1,0
  - S = 010: 00,01,1,0,1,0,0,0
  - I = 011: 10,00,1,0,0,0,1,0
  - B = 100: 01,10,0,1,0,0,0,0
  - J = 101: 00,10,0,0,0,0,1,1
  - F = 110: 11,00,0,0,0,1,1,0
- All-zero bundle: op = 111 (bubble/default), err = 0.
- Any other bundle: op = 111, err = 1.

Push (when ret_valid = 1):
- A push is accepted if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
- Accepted push: the record is written with lost equal to the sticky lost flag, then the sticky flag clears.
- Rejected push: sticky lost is set and drop_cnt increments, saturating at 255.

Pop:
- A pop occurs when out_valid && out_ready.
- out_rec always shows the head entry and holds stable while out_valid = 1 and out_ready = 0.

drop_clr:
- drop_cnt goes to 0. If a drop happens in the same cycle, drop_cnt goes to 1.
- drop_clr does not affect sticky lost.

Pointers:
- Read and write pointers are $clog2(DEPTH)+1 bits wide and wrap naturally.
- full when the MSBs differ and the rest are equal; empty when the pointers are equal.

## Timing
- Reset (clk edge with rst = 1): pointers = 0, out_valid = 0, fifo_level = 0, drop_cnt = 0, sticky lost = 0. out_rec is don't-care while out_valid = 0.
- Latency: a record pushed at edge N is visible on out_rec with out_valid = 1 after edge N when the FIFO was empty. There is no combinational fall-through from ret_* to out_*.
- fifo_level updates on the same edge as the push/pop; a simultaneous push and pop leaves it unchanged.
- Full with simultaneous push and pop: both are accepted, level stays DEPTH, no drop.
- Empty with out_ready = 1 and ret_valid = 1: the record lands; out_valid rises after the edge.
- rst mid-stream discards all buffered records and the drop state. The first push after reset has lost = 0.
- ret_valid is sampled every cycle, including the first cycle after reset deasserts.

## Structure
Shared package cpu_pkg:
- op-class constants OP_R, OP_L, OP_S, OP_I, OP_B, OP_J, OP_F, OP_NONE (111)
- the seven 10-bit control-signature constants, so the decoder and this encoder share one source of truth
- the trace record field offsets

Sub-modules:
- One sub-module, trace_fifo: a parameterized synchronous FIFO with level output.
- Encoding, loss tagging and the drop counter live in the top.

## Test plan
- Reset, then push the R signature with pc 0x100 → after one edge, out_valid = 1 and out_rec = {0,0,000,0x100}.
- Push each of the 7 legal signatures plus all-zero, one per cycle, with out_ready = 1 → ops 000..110 then 111, all err = 0, in order.
- Push bundle 11,01,1,1,1,1,1,1 → op = 111, err = 1.
- out_ready = 0 for DEPTH+3 pushes → fifo_level = 8, drop_cnt = 3. Then raise out_ready and push pc 0x200 → record 0x200 has lost = 1; the next record has lost = 0.
- Full FIFO with a simultaneous push and pop → no drop, level stays 8, FIFO order preserved across pointer wrap.
- drop_cnt forced to 255 by 300 drops → holds at 255. drop_clr together with a drop → 1. Assert rst with 5 entries buffered → out_valid = 0 and level = 0 after the edge.
